// File: rtl/spi_arbiter.sv
// spi_arbiter: grants the shared spi_core byte engine to one of two requesters per framed transaction
module spi_arbiter #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_req,
    input  logic       r1_req,
    output logic       r0_grant,
    output logic       r1_grant,
    input  logic       r0_start,
    input  logic       r1_start,
    input  logic [7:0] r0_data_tx,
    input  logic [7:0] r1_data_tx,
    output logic       r0_done,
    output logic       r1_done,
    output logic [7:0] rx_data,
    output logic       proto_err,
    output logic [7:0] spi_data_tx,
    output logic       spi_txn_start,
    input  logic [7:0] spi_data_rx,
    input  logic       spi_txn_done
);
    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_GAP} state_t;

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic       r_owner, w_owner_nxt;
    logic       r_last_owner, w_last_nxt;
    logic       r_busy, w_busy_nxt;
    logic [3:0] r_gap_cnt, w_gap_nxt;
    logic       r_grant0, r_grant1;
    logic       r_start, r_perr;
    logic [7:0] r_data_tx;
    logic       w_own_req, w_own_start, w_own_grant;
    logic       w_accept, w_reject, w_done_hit;
    logic [7:0] w_own_data;

    // Owner-relative views of the request side, plus accept/reject/complete decisions
    always_comb begin
        w_own_req   = r_owner ? r1_req     : r0_req;
        w_own_start = r_owner ? r1_start   : r0_start;
        w_own_grant = r_owner ? r_grant1   : r_grant0;
        w_own_data  = r_owner ? r1_data_tx : r0_data_tx;
        w_accept    = w_own_grant & w_own_start & ~r_busy;
        w_reject    = (r0_start & ~(r_grant0 & ~r_busy)) | (r1_start & ~(r_grant1 & ~r_busy));
        w_done_hit  = spi_txn_done & r_busy;
        w_busy_nxt  = (r_busy & ~spi_txn_done) | w_accept;
    end

    // Ownership FSM: arbitrate in IDLE, hold through the frame in OWN, enforce the idle gap in GAP
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r0_req | r1_req) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = (r0_req & r1_req) ? ~r_last_owner : r1_req;
                end
            end
            ST_OWN: begin
                if (~w_own_req & ~w_busy_nxt) begin
                    w_last_nxt  = r_owner;
                    w_gap_nxt   = GAP_LAST;
                    w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_nxt = (r_gap_cnt == 4'd0) ? ST_IDLE : ST_GAP;
                w_gap_nxt   = (r_gap_cnt == 4'd0) ? 4'd0 : r_gap_cnt - 4'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control state registers; owner history starts at 1 so port 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b1;
            r_last_owner <= 1'b1;
            r_busy       <= 1'b0;
            r_gap_cnt    <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_busy       <= w_busy_nxt;
            r_gap_cnt    <= w_gap_nxt;
        end
    end

    // Registered grants, engine start/data and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
            r_start   <= 1'b0;
            r_perr    <= 1'b0;
            r_data_tx <= 8'h00;
        end else begin
            r_grant0  <= (w_state_nxt == ST_OWN) & ~w_owner_nxt;
            r_grant1  <= (w_state_nxt == ST_OWN) & w_owner_nxt;
            r_start   <= w_accept;
            r_perr    <= w_reject;
            r_data_tx <= w_accept ? w_own_data : r_data_tx;
        end
    end

    assign r0_grant      = r_grant0;
    assign r1_grant      = r_grant1;
    assign spi_txn_start = r_start;
    assign proto_err     = r_perr;
    assign spi_data_tx   = r_data_tx;
    assign rx_data       = spi_data_rx;
    assign r0_done       = w_done_hit & ~r_owner;
    assign r1_done       = w_done_hit & r_owner;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: two builds (GAP_CYCLES=1 and 0) checked cycle by cycle against a transaction-level model
module tb_spi_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] r0_req, r1_req, r0_start, r1_start, r0_grant, r1_grant;
    logic [1:0] r0_done, r1_done, proto_err, spi_txn_start, spi_txn_done;
    logic [7:0] r0_data_tx [2];
    logic [7:0] r1_data_tx [2];
    logic [7:0] rx_data [2];
    logic [7:0] spi_data_tx [2];
    logic [7:0] spi_data_rx [2];

    always #5 clk = ~clk;

    spi_arbiter #(.GAP_CYCLES(1)) u_gap1 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req[0]), .r1_req(r1_req[0]), .r0_grant(r0_grant[0]), .r1_grant(r1_grant[0]),
        .r0_start(r0_start[0]), .r1_start(r1_start[0]), .r0_data_tx(r0_data_tx[0]), .r1_data_tx(r1_data_tx[0]),
        .r0_done(r0_done[0]), .r1_done(r1_done[0]), .rx_data(rx_data[0]), .proto_err(proto_err[0]),
        .spi_data_tx(spi_data_tx[0]), .spi_txn_start(spi_txn_start[0]),
        .spi_data_rx(spi_data_rx[0]), .spi_txn_done(spi_txn_done[0])
    );

    spi_arbiter #(.GAP_CYCLES(0)) u_gap0 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req[1]), .r1_req(r1_req[1]), .r0_grant(r0_grant[1]), .r1_grant(r1_grant[1]),
        .r0_start(r0_start[1]), .r1_start(r1_start[1]), .r0_data_tx(r0_data_tx[1]), .r1_data_tx(r1_data_tx[1]),
        .r0_done(r0_done[1]), .r1_done(r1_done[1]), .rx_data(rx_data[1]), .proto_err(proto_err[1]),
        .spi_data_tx(spi_data_tx[1]), .spi_txn_start(spi_txn_start[1]),
        .spi_data_rx(spi_data_rx[1]), .spi_txn_done(spi_txn_done[1])
    );

    int n_cmp = 0;
    int n_err = 0;
    int gap_cfg [2] = '{1, 0};

    // Model: who holds the engine (-1 = nobody), idle cycles still owed, round-robin memory, byte in flight
    int         m_own [2];
    int         m_gap_left [2];
    int         m_last [2];
    bit         m_busy [2];
    bit         m_start [2];
    bit         m_perr [2];
    logic [7:0] m_tx [2];

    bit         cap = 1'b0;
    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    int         r1_done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_own[k]      = -1;
        m_gap_left[k] = 0;
        m_last[k]     = 1;
        m_busy[k]     = 1'b0;
        m_start[k]    = 1'b0;
        m_perr[k]     = 1'b0;
        m_tx[k]       = 8'h00;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            r0_req[k] = 0; r1_req[k] = 0; r0_start[k] = 0; r1_start[k] = 0;
            r0_data_tx[k] = 0; r1_data_tx[k] = 0; spi_txn_done[k] = 0; spi_data_rx[k] = 0;
        end
    endtask

    // Compare instance k against the model for this cycle, then advance the model over the coming edge
    task automatic check_step(input int k);
        bit         q [2];
        bit         s [2];
        logic [7:0] d [2];
        int         own;
        bit         dn0, dn1, acc, bad, inflight;
        q[0] = r0_req[k];   q[1] = r1_req[k];
        s[0] = r0_start[k]; s[1] = r1_start[k];
        d[0] = r0_data_tx[k]; d[1] = r1_data_tx[k];
        own = m_own[k];
        dn0 = spi_txn_done[k] && m_busy[k] && own == 0;
        dn1 = spi_txn_done[k] && m_busy[k] && own == 1;
        check($sformatf("r0_grant/i%0d", k), r0_grant[k], own == 0);
        check($sformatf("r1_grant/i%0d", k), r1_grant[k], own == 1);
        check($sformatf("spi_txn_start/i%0d", k), spi_txn_start[k], m_start[k]);
        check($sformatf("spi_data_tx/i%0d", k), spi_data_tx[k], m_tx[k]);
        check($sformatf("proto_err/i%0d", k), proto_err[k], m_perr[k]);
        check($sformatf("r0_done/i%0d", k), r0_done[k], dn0);
        check($sformatf("r1_done/i%0d", k), r1_done[k], dn1);
        check($sformatf("rx_data/i%0d", k), rx_data[k], spi_data_rx[k]);
        acc = own >= 0 && s[own] && !m_busy[k];
        bad = (s[0] && !(own == 0 && !m_busy[k])) || (s[1] && !(own == 1 && !m_busy[k]));
        inflight = (m_busy[k] && !spi_txn_done[k]) || acc;
        m_perr[k]  = bad;
        m_start[k] = acc;
        if (acc) m_tx[k] = d[own];
        m_busy[k] = inflight;
        if (own >= 0) begin
            if (!q[own] && !inflight) begin
                m_last[k]     = own;
                m_own[k]      = -1;
                m_gap_left[k] = gap_cfg[k];
            end
        end else if (m_gap_left[k] > 0) m_gap_left[k]--;
        else if (q[0] && q[1]) m_own[k] = 1 - m_last[k];
        else if (q[0]) m_own[k] = 0;
        else if (q[1]) m_own[k] = 1;
    endtask

    // Called just after a falling edge with inputs set; checks, crosses one rising edge, clears pulses
    task automatic run_cycle();
        #1;
        if (cap) begin
            if (r0_done[0]) rx_q.push_back(rx_data[0]);
            if (r1_done[0]) r1_done_cnt++;
            if (spi_txn_start[0]) tx_q.push_back(spi_data_tx[0]);
        end
        for (int k = 0; k < 2; k++) check_step(k);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            r0_start[k] = 0; r1_start[k] = 0; spi_txn_done[k] = 0;
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Asynchronous reset with no clock edge before the check; a pending engine completion must not leak through
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        spi_txn_done = 2'b11;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_grant/i%0d", k), {r1_grant[k], r0_grant[k]}, 2'b00);
            check($sformatf("rst_start/i%0d", k), spi_txn_start[k], 1'b0);
            check($sformatf("rst_perr/i%0d", k), proto_err[k], 1'b0);
            check($sformatf("rst_done/i%0d", k), {r1_done[k], r0_done[k]}, 2'b00);
            check($sformatf("rst_data_tx/i%0d", k), spi_data_tx[k], 8'h00);
            model_reset(k);
        end
        spi_txn_done = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input bit a, input bit b);
        r0_req = {a, a};
        r1_req = {b, b};
    endtask

    task automatic start0(input logic [7:0] v);
        r0_start = 2'b11;
        r0_data_tx[0] = v; r0_data_tx[1] = v;
    endtask

    task automatic start1(input logic [7:0] v);
        r1_start = 2'b11;
        r1_data_tx[0] = v; r1_data_tx[1] = v;
    endtask

    task automatic complete(input logic [7:0] v);
        spi_txn_done = 2'b11;
        spi_data_rx[0] = v; spi_data_rx[1] = v;
    endtask

    logic [7:0] exp_tx [3] = '{8'h03, 8'h00, 8'h10};
    logic [7:0] exp_rx [3] = '{8'hAA, 8'hBB, 8'hCC};

    initial begin
        do_reset();
        // single owner, three bytes each after the previous completion
        cap = 1'b1;
        set_req(1, 0);
        run_cycle();
        for (int i = 0; i < 3; i++) begin
            start0(exp_tx[i]);
            run_n(2);
            complete(exp_rx[i]);
            run_cycle();
        end
        set_req(0, 0);
        run_n(3);
        cap = 1'b0;
        check("r0_done_count", rx_q.size(), 3);
        check("r1_done_count", r1_done_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rx_seq%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_rx[i]);
            check($sformatf("tx_seq%0d", i), (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_tx[i]);
        end
        // contention after reset, handover through the gap, round-robin on the second contention
        do_reset();
        set_req(1, 1);
        run_n(3);
        set_req(0, 1);
        run_n(4);
        set_req(0, 0);
        run_n(3);
        set_req(1, 1);
        run_n(3);
        set_req(0, 0);
        run_n(3);
        // owner drops its request while its byte is in flight
        set_req(0, 1);
        run_n(2);
        start1(8'h5A);
        run_cycle();
        set_req(0, 0);
        run_n(2);
        complete(8'h77);
        run_n(4);
        // rejected starts: from the non-owner, then from the owner while busy
        set_req(1, 0);
        run_n(2);
        start1(8'hEE);
        run_cycle();
        start0(8'h11);
        run_cycle();
        start0(8'h22);
        run_n(2);
        complete(8'h33);
        set_req(0, 0);
        run_n(4);
        // reset while the start pulse is on its way to the engine
        set_req(1, 0);
        run_n(2);
        start0(8'h44);
        run_cycle();
        do_reset();
        set_req(0, 1);
        run_n(3);
        set_req(0, 0);
        run_n(3);
        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(7) == 0) r0_req[k] = ~r0_req[k];
                if ($urandom_range(7) == 0) r1_req[k] = ~r1_req[k];
                r0_start[k]     = ($urandom_range(2) == 0);
                r1_start[k]     = ($urandom_range(3) == 0);
                r0_data_tx[k]   = 8'($urandom);
                r1_data_tx[k]   = 8'($urandom);
                spi_txn_done[k] = ($urandom_range(2) == 0);
                spi_data_rx[k]  = 8'($urandom);
            end
            run_cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the single `spi_core` byte engine between two requesters: port 0 is the memory controller and port 1 is the register-space SPI peripheral. The arbiter grants ownership of the SPI byte stream for a whole framed transaction, so a requester keeps the engine across many bytes while its chip select is low. It forwards byte starts and routes completions back to the owner, and it enforces an idle gap between owners. It sits in `soc` between the requesters and `spi_core`.

## Interface
Parameters:
- `GAP_CYCLES`, default 1: idle cycles inserted after an owner releases, before any new grant. Range 0..15.

Ports:
- `clk`  in  1: system clock; everything is on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `r0_req`, `r1_req`  in  1 each: requester holds this high for the whole transaction frame.
- `r0_grant`, `r1_grant`  out  1 each: registered; the requester owns the SPI engine. At most one is high.
- `r0_start`, `r1_start`  in  1 each: one-cycle pulse requesting one byte transfer.
- `r0_data_tx`, `r1_data_tx`  in  8 each: byte to send; sampled on an accepted start.
- `r0_done`, `r1_done`  out  1 each: one-cycle pulse when the owner's byte completes.
- `rx_data`  out  8: `spi_data_rx` passed straight through, broadcast to both requesters.
- `proto_err`  out  1: one-cycle pulse when a start is rejected.
- `spi_data_tx`  out  8: registered byte to `spi_core`.
- `spi_txn_start`  out  1: registered one-cycle start pulse to `spi_core`.
- `spi_data_rx`  in  8: received byte from `spi_core`.
- `spi_txn_done`  in  1: one-cycle completion pulse from `spi_core`.

## Operation
- State machine: IDLE, OWN, GAP. Also keeps `owner` (1 bit), `last_owner` (1 bit), `busy` (byte in flight), and a 4-bit gap counter.
- IDLE:
  - One requester has `req` high: grant that requester.
  - Both have `req` high: grant the requester that is not `last_owner` (round-robin).
  - On grant: move to OWN, set the matching `rN_grant` on the next edge, set `owner`.
- OWN, start handling:
  - Owner pulses `start` while `grant` is high and `busy` is 0: latch its `data_tx` into `spi_data_tx`, pulse `spi_txn_start` for one cycle, set `busy`.
- OWN, rejected starts: each of these pulses `proto_err` for one cycle and is otherwise ignored:
  - a start from the requester that does not own the engine;
  - a start while `busy` is 1;
  - a start from a requester that is not granted.
- OWN, completion: `spi_txn_done` while `busy` is 1 produces `rN_done` for the owner (combinational, same cycle) and clears `busy`. `spi_txn_done` while `busy` is 0 is ignored.
- OWN, release:
  - Owner's `req` is low and `busy` is 0 (evaluated after this cycle's completion is applied): clear the grant, set `last_owner = owner`.
  - Then go to GAP, or straight to IDLE if `GAP_CYCLES` is 0.
- GAP: count `GAP_CYCLES` cycles, then go to IDLE. Requests made during GAP wait and are arbitrated in IDLE.
- The owner dropping `req` while `busy` is 1 does not release the engine. The arbiter holds ownership until `spi_txn_done`, then releases.
- A requester dropping `req` while it is not granted simply withdraws its request. There is no penalty.

## Timing
- Reset values:
  - `r0_grant`, `r1_grant`, `spi_txn_start`, `proto_err`, `busy`: 0.
  - `spi_data_tx`: 0x00.
  - `owner`, `last_owner`: 1, so port 0 wins the first contention.
  - State: IDLE. `rN_done` is 0 because `busy` is 0.
- Reset asserted mid-transfer clears everything immediately (asynchronous). `spi_core` shares `rst_n`, so there is no orphaned transfer.
- Request to grant: `req` sampled high in IDLE at edge N gives `grant` high after edge N+1 (one cycle).
- Start to engine: `rN_start` high at edge N gives `spi_txn_start` high for the cycle after edge N, with `spi_data_tx` valid from that same edge.
- Completion: `rN_done` is asserted in the same cycle as `spi_txn_done` (zero latency).
- Handover: last `rN_done` with `req` already low gives `grant` low after the next edge. The other requester's grant rises GAP_CYCLES+1 cycles later at minimum.
- Back-to-back bytes: the owner may pulse `start` in the cycle after `done`. Byte-to-byte overhead is one cycle.

## Test plan
- Single owner: r0_req high, 3 starts with data 0x03, 0x00, 0x10, each issued after the previous done; spi model returns 0xAA, 0xBB, 0xCC -> spi_data_tx sequence 0x03, 0x00, 0x10; r0_done exactly 3 pulses with rx_data = 0xAA, 0xBB, 0xCC; r1_done never pulses.
- Contention after reset: r0_req and r1_req rise together -> r0_grant first. After r0 releases, with GAP_CYCLES=1: r1_grant rises exactly 2 cycles after r0_grant falls. A second simultaneous contention then goes to r0 again (round-robin).
- Release during byte: r1 drops req the cycle after its start -> r1_grant stays high until spi_txn_done, falls the cycle after, and r1_done pulses once.
- Protocol errors: r1_start while r0 owns; r0_start while busy -> proto_err pulses twice, no extra spi_txn_start, spi_data_tx unchanged.
- Async reset mid-transfer: rst_n low while busy -> grants, spi_txn_start and busy drop to 0 without a clock edge. After release, r1-only request -> r1_grant in 1 cycle.
- GAP_CYCLES=0 build: release -> the other requester's grant rises 1 cycle after the previous grant falls.
